// File: rtl/cic_output_scaler.sv
// Gain-normalizing output stage for the CIC interpolator: round-half-up arithmetic
// right shift, saturation to OUT_WIDTH, two-stage elastic AXI-stream pipeline.
module cic_output_scaler #(
   parameter int IN_WIDTH    = 18,
   parameter int OUT_WIDTH   = 16,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [IN_WIDTH-1:0]    input_tdata,
   input  logic                   input_tvalid,
   output logic                   input_tready,
   output logic [OUT_WIDTH-1:0]   output_tdata,
   output logic                   output_tvalid,
   input  logic                   output_tready,
   input  logic [SHIFT_WIDTH-1:0] shift,
   output logic                   sat_flag,
   input  logic                   sat_clear
);

   // Internal shift width must hold both the raw control and IN_WIDTH-1.
   localparam int S_W = (SHIFT_WIDTH > $clog2(IN_WIDTH)) ? SHIFT_WIDTH : $clog2(IN_WIDTH);
   localparam logic [S_W-1:0] S_LIMIT = S_W'(IN_WIDTH - 1);

   localparam logic signed [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [OUT_WIDTH-1:0] MAX_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};
   localparam logic signed [IN_WIDTH:0] MAX_POS_W = {{(IN_WIDTH+1-OUT_WIDTH){1'b0}}, MAX_POS};
   localparam logic signed [IN_WIDTH:0] MAX_NEG_W = {{(IN_WIDTH+1-OUT_WIDTH){1'b1}}, MAX_NEG};

   // Rounding add; the extra MSB keeps max-positive + 2^(s-1) from wrapping.
   function automatic logic [IN_WIDTH:0] round_add(input logic [IN_WIDTH-1:0] x,
                                                  input logic [S_W-1:0]      s);
      logic [IN_WIDTH:0] rc;
      rc = '0;
      if (s != '0) rc = (IN_WIDTH+1)'(1) << (s - S_W'(1));
      return {x[IN_WIDTH-1], x} + rc;
   endfunction

   // Returns {saturated, data}.
   function automatic logic [OUT_WIDTH:0] shift_sat(input logic [IN_WIDTH:0] sum,
                                                   input logic [S_W-1:0]    s);
      logic signed [IN_WIDTH:0] sh;
      sh = $signed(sum) >>> s;
      if (sh > MAX_POS_W)      return {1'b1, MAX_POS};
      else if (sh < MAX_NEG_W) return {1'b1, MAX_NEG};
      else                     return {1'b0, sh[OUT_WIDTH-1:0]};
   endfunction

   logic                 v1, v2;
   logic [IN_WIDTH:0]    sum1;
   logic [S_W-1:0]       s1;
   logic [OUT_WIDTH-1:0] data2;
   logic                 sat_q;
   logic                 adv1, adv2;
   logic [S_W-1:0]       s_in;
   logic [OUT_WIDTH:0]   st2_res;

   // Handshake: a beat moves on valid && ready. Each stage advances when it is empty or
   // the stage after it advances; input_tready never looks at input_tvalid, and the
   // output_tready -> input_tready path is combinational.
   always_comb begin
      adv2         = ~v2 | output_tready;
      adv1         = ~v1 | adv2;
      input_tready = adv1 & ~rst;
      s_in         = (S_W'(shift) > S_LIMIT) ? S_LIMIT : S_W'(shift);
      st2_res      = shift_sat(sum1, s1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         sum1  <= '0;
         s1    <= '0;
         data2 <= '0;
         sat_q <= 1'b0;
      end else begin
         if (adv1) begin
            v1 <= input_tvalid;
            if (input_tvalid) begin
               sum1 <= round_add(input_tdata, s_in);
               s1   <= s_in;
            end
         end
         if (adv2) begin
            v2 <= v1;
            if (v1) data2 <= st2_res[OUT_WIDTH-1:0];
         end
         // Set beats clear when both happen in the same cycle.
         if (adv2 && v1 && st2_res[OUT_WIDTH]) sat_q <= 1'b1;
         else if (sat_clear)                   sat_q <= 1'b0;
      end
   end

   assign output_tdata  = data2;
   assign output_tvalid = v2;
   assign sat_flag      = sat_q;

endmodule

// File: tb/tb_cic_output_scaler.sv
// Directed bench for cic_output_scaler: hand-computed vectors, expected-queue
// scoreboard on the output stream, plus latency, flag, backpressure and reset checks.
module tb_cic_output_scaler;
   localparam int IN_W  = 18;
   localparam int OUT_W = 16;
   localparam int SH_W  = 5;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [IN_W-1:0]  input_tdata = '0;
   logic             input_tvalid = 1'b0;
   logic             input_tready;
   logic [OUT_W-1:0] output_tdata;
   logic             output_tvalid;
   logic             output_tready = 1'b1;
   logic [SH_W-1:0]  shift = '0;
   logic             sat_flag;
   logic             sat_clear = 1'b0;

   cic_output_scaler #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT_WIDTH(SH_W)) dut (
      .clk(clk), .rst(rst),
      .input_tdata(input_tdata), .input_tvalid(input_tvalid), .input_tready(input_tready),
      .output_tdata(output_tdata), .output_tvalid(output_tvalid), .output_tready(output_tready),
      .shift(shift), .sat_flag(sat_flag), .sat_clear(sat_clear)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [OUT_W-1:0] exp_q[$];

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // scoreboard: a beat transfers at the next posedge when valid && ready at negedge
   always @(negedge clk) begin
      if (!rst && output_tvalid && output_tready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", int'($signed(output_tdata)), 0);
         end else begin
            logic [OUT_W-1:0] e;
            e = exp_q.pop_front();
            check("out_data", int'($signed(output_tdata)), int'($signed(e)));
         end
      end
   end

   // driver: present a beat at #1 after posedge, hold until accepted
   task automatic send(input int data, input int sh, input int exp);
      bit acc;
      int budget;
      exp_q.push_back(OUT_W'(exp));
      input_tdata  = IN_W'(data);
      shift        = SH_W'(sh);
      input_tvalid = 1'b1;
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 50) begin
         @(negedge clk);
         acc = input_tready;
         @(posedge clk);
         #1;
         budget++;
      end
      if (!acc) check("accept_timeout", 0, 1);
      input_tvalid = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 50) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check("drain", int'(exp_q.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", int'(output_tvalid), 0);
      check("rst_tdata", int'(output_tdata), 0);
      check("rst_sat", int'(sat_flag), 0);
      check("rst_tready", int'(input_tready), 0);
      rst = 1'b0;
      #1;
      check("post_rst_tready", int'(input_tready), 1);
      @(posedge clk);
      #1;

      // basic shift and latency: (1001+2)>>2 = 250
      send(1001, 2, 250);
      check("lat1_valid", int'(output_tvalid), 0);
      @(posedge clk);
      #1;
      check("lat2_valid", int'(output_tvalid), 1);
      check("lat2_data", int'($signed(output_tdata)), 250);
      drain();
      check("basic_sat", int'(sat_flag), 0);

      // rounding half toward +inf, range edges without saturation, shift clamp
      send(3, 1, 2);
      send(-3, 1, -1);
      send(-5, 1, -2);
      send(6, 2, 2);
      send(-6, 2, -1);
      send(65534, 1, 32767);
      send(-65536, 1, -32768);
      send(131071, 31, 1);
      send(-131072, 31, -1);
      drain();
      check("round_sat", int'(sat_flag), 0);

      // saturation
      send(40000, 0, 32767);
      send(-40000, 0, -32768);
      send(131071, 1, 32767);
      drain();
      check("sat_set", int'(sat_flag), 1);
      sat_clear = 1'b1;
      @(posedge clk);
      #1;
      sat_clear = 1'b0;
      check("sat_cleared", int'(sat_flag), 0);
      // clear held across the saturating load: set wins
      sat_clear = 1'b1;
      send(50000, 0, 32767);
      @(posedge clk);
      #1;
      sat_clear = 1'b0;
      check("sat_set_wins", int'(sat_flag), 1);
      drain();

      // backpressure: two beats absorbed, then input_tready falls
      output_tready = 1'b0;
      send(1, 0, 1);
      send(2, 0, 2);
      check("bp_ready_low", int'(input_tready), 0);
      check("bp_hold_valid", int'(output_tvalid), 1);
      check("bp_hold_data", int'($signed(output_tdata)), 1);
      fork
         begin
            send(3, 0, 3);
            send(4, 0, 4);
         end
         begin
            repeat (3) begin
               @(posedge clk);
               #1;
               check("bp_stall_data", int'($signed(output_tdata)), 1);
            end
            output_tready = 1'b1;
         end
      join
      drain();

      // shift change on consecutive beats
      send(256, 4, 16);
      send(256, 0, 256);
      drain();

      // reset mid-stream with both stages full and sat_flag set
      output_tready = 1'b0;
      send(7, 0, 7);
      send(8, 0, 8);
      check("pre_rst_full", int'(output_tvalid), 1);
      exp_q.delete();
      rst = 1'b1;
      #1;
      check("mid_rst_tvalid", int'(output_tvalid), 0);
      check("mid_rst_sat", int'(sat_flag), 0);
      check("mid_rst_tready", int'(input_tready), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      output_tready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("no_stale", int'(output_tvalid), 0);
      send(100, 2, 25);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
